// File: rtl/m31_vector_subtractor_pkg.sv
// Shared Mersenne-31 definitions: field modulus, element type, subtractor FSM states.
package m31_vector_subtractor_pkg;

  localparam int          M31_W = 31;
  localparam logic [30:0] M31_P = 31'h7FFF_FFFF;

  typedef logic [M31_W-1:0] m31_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COMPUTE,
    ST_DONE
  } state_e;

  // p is a second encoding of zero; fold it onto the canonical one
  function automatic m31_t m31_canon(input m31_t x);
    return (x == M31_P) ? '0 : x;
  endfunction

endpackage

// File: rtl/m31_subtractor.sv
// Combinational single-element M31 modular subtractor: d = (a - b) mod p.
module m31_subtractor
  import m31_vector_subtractor_pkg::*;
(
  input  m31_t a,
  input  m31_t b,
  output m31_t d
);

  logic signed [M31_W:0] diff;

  // A negative difference lies in (-p, 0); adding p once brings it into range,
  // and the 31-bit wrap of the sum discards the borrow bit.
  function automatic m31_t fold_borrow(input logic signed [M31_W:0] x);
    if (x < 0) return x[M31_W-1:0] + M31_P;
    else       return x[M31_W-1:0];
  endfunction

  assign diff = $signed({1'b0, a}) - $signed({1'b0, b});
  assign d    = fold_borrow(diff);

endmodule

// File: rtl/m31_vector_subtractor.sv
// Element-wise M31 vector subtractor, LANES elements per beat over a shared subtractor bank.
// Optional build macro M31_VEC_SUB_CANONICAL_EN maps operands equal to p onto 0 at capture.
module m31_vector_subtractor
  import m31_vector_subtractor_pkg::*;
#(
  parameter int WORD_WIDTH  = 31,
  parameter int VECTOR_SIZE = 16,
  parameter int LANES       = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] vec1   [0:VECTOR_SIZE-1],
  input  logic [WORD_WIDTH-1:0] vec2   [0:VECTOR_SIZE-1],
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] result [0:VECTOR_SIZE-1],
  output logic                  busy
);

  localparam int BEATS  = VECTOR_SIZE / LANES;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  if (WORD_WIDTH != 31) begin : g_bad_width
    $error("m31_vector_subtractor: WORD_WIDTH must be 31");
  end
  if ((LANES < 1) || (VECTOR_SIZE % LANES != 0)) begin : g_bad_lanes
    $error("m31_vector_subtractor: LANES must divide VECTOR_SIZE");
  end

  state_e              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q;
  logic                accept;
  logic                last_beat;
  m31_t                op1_q    [0:VECTOR_SIZE-1];
  m31_t                op2_q    [0:VECTOR_SIZE-1];
  m31_t                result_q [0:VECTOR_SIZE-1];
  m31_t                lane_a   [0:LANES-1];
  m31_t                lane_b   [0:LANES-1];
  m31_t                lane_d   [0:LANES-1];

  function automatic m31_t capture_op(input m31_t x);
`ifdef M31_VEC_SUB_CANONICAL_EN
    return m31_canon(x);
`else
    return x;
`endif
  endfunction

  assign accept    = in_valid && in_ready;
  assign last_beat = (beat_q == BEAT_W'(BEATS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ST_COMPUTE;
      end
      ST_COMPUTE: begin
        busy = 1'b1;
        if (last_beat) state_d = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Beat select: route this beat's slice of the operands onto the lanes
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_a[l] = '0;
      lane_b[l] = '0;
    end
    for (int b = 0; b < BEATS; b++) begin
      if (beat_q == BEAT_W'(b)) begin
        for (int l = 0; l < LANES; l++) begin
          lane_a[l] = op1_q[b*LANES + l];
          lane_b[l] = op2_q[b*LANES + l];
        end
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    m31_subtractor u_sub (
      .a (lane_a[l]),
      .b (lane_b[l]),
      .d (lane_d[l])
    );
  end

  // Capture on acceptance; write one beat of results per COMPUTE cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q <= '0;
      for (int i = 0; i < VECTOR_SIZE; i++) begin
        op1_q[i]    <= '0;
        op2_q[i]    <= '0;
        result_q[i] <= '0;
      end
    end else if (accept) begin
      beat_q <= '0;
      for (int i = 0; i < VECTOR_SIZE; i++) begin
        op1_q[i] <= capture_op(vec1[i]);
        op2_q[i] <= capture_op(vec2[i]);
      end
    end else if (state_q == ST_COMPUTE) begin
      beat_q <= last_beat ? '0 : beat_q + BEAT_W'(1);
      for (int b = 0; b < BEATS; b++) begin
        if (beat_q == BEAT_W'(b)) begin
          for (int l = 0; l < LANES; l++) begin
            result_q[b*LANES + l] <= lane_d[l];
          end
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < VECTOR_SIZE; i++) result[i] = result_q[i];
  end

endmodule

// File: tb/tb_m31_vector_subtractor.sv
// Self-checking bench for m31_vector_subtractor against a behavioural M31 model.
// Define M31_VEC_SUB_CANONICAL_EN to also exercise the operand==p mapping.
module tb_m31_vector_subtractor;

  localparam int          VS    = 16;
  localparam int          LN    = 4;
  localparam int          BEATS = VS / LN;
  localparam logic [30:0] P     = 31'h7FFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [30:0] v1 [0:VS-1];
  logic [30:0] v2 [0:VS-1];
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [30:0] result [0:VS-1];
  logic        busy;

  int checks = 0;
  int errors = 0;

  // Model state: a transaction is outstanding from acceptance to output handshake
  logic        pending = 1'b0;
  int          cnt = 0;
  int          n_acc = 0;
  logic [30:0] exp_vec [0:VS-1];
  logic        exp_ov, exp_ir, exp_busy;

  always #5 clk = ~clk;

  m31_vector_subtractor #(.WORD_WIDTH(31), .VECTOR_SIZE(VS), .LANES(LN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .vec1      (v1),
    .vec2      (v2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  function automatic logic [30:0] mod_sub(input logic [30:0] a, input logic [30:0] b);
    longint d;
`ifdef M31_VEC_SUB_CANONICAL_EN
    if (a == P) a = '0;
    if (b == P) b = '0;
`endif
    d = longint'(a) - longint'(b);
    if (d < 0) d = d + longint'(P);
    return d[30:0];
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: result becomes valid BEATS edges after acceptance, held until handshake
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 1'b0;
      cnt     <= 0;
    end else if (!pending) begin
      if (in_valid) begin
        pending <= 1'b1;
        cnt     <= 0;
        n_acc   <= n_acc + 1;
        for (int i = 0; i < VS; i++) exp_vec[i] <= mod_sub(v1[i], v2[i]);
      end
    end else if (cnt >= BEATS) begin
      if (out_ready) pending <= 1'b0;
    end else begin
      cnt <= cnt + 1;
    end
  end

  assign exp_ov   = pending && (cnt >= BEATS);
  assign exp_ir   = !pending;
  assign exp_busy = pending;

  always @(negedge clk) begin
    chk("in_ready", longint'(in_ready), longint'(exp_ir));
    chk("out_valid", longint'(out_valid), longint'(exp_ov));
    chk("busy", longint'(busy), longint'(exp_busy));
    if (exp_ov) begin
      int bad;
      bad = -1;
      for (int i = 0; i < VS; i++) if (bad < 0 && result[i] !== exp_vec[i]) bad = i;
      checks++;
      if (bad >= 0) begin
        errors++;
        $display("FAIL result[%0d]: got %0d, expected %0d (t=%0t)",
                 bad, result[bad], exp_vec[bad], $time);
      end
    end
  end

  task automatic load(input int mode);
    for (int i = 0; i < VS; i++) begin
      case (mode)
        0: begin v1[i] = 31'd5;          v2[i] = 31'd0;          end
        1: begin v1[i] = 31'd0;          v2[i] = 31'd5;          end
        2: begin v1[i] = 31'h1234_5678;  v2[i] = 31'h1234_5678;  end
        3: begin v1[i] = 31'(i);         v2[i] = 31'(15 - i);    end
        5: begin v1[i] = P;              v2[i] = 31'd1;          end
        6: begin v1[i] = P;              v2[i] = 31'd0;          end
        default: begin
          v1[i] = 31'($urandom_range(0, 32'h7FFF_FFFE));
          v2[i] = 31'($urandom_range(0, 32'h7FFF_FFFE));
        end
      endcase
    end
  endtask

  task automatic send();
    int k;
    k = 0;
    while (!in_ready && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 50) chk("send_timeout", 1, 0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_ov(output int edges);
    edges = 0;
    while (!out_valid && edges < 50) begin
      @(posedge clk); #1;
      edges++;
    end
    if (edges >= 50) chk("done_timeout", 1, 0);
  endtask

  task automatic chk_all(input string name, input longint exp);
    for (int i = 0; i < VS; i++) chk($sformatf("%s[%0d]", name, i), longint'(result[i]), exp);
  endtask

  initial begin
    int e;
    load(0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", longint'(in_ready), 1);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_busy", longint'(busy), 0);
    chk_all("rst_result", 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic patterns with hand-computed expectations
    load(0); send(); wait_ov(e);
    chk("latency_edges", e, BEATS);
    chk_all("five_minus_zero", 5);
    load(1); send(); wait_ov(e);
    chk_all("zero_minus_five", 2147483642);
    load(2); send(); wait_ov(e);
    chk_all("equal_operands", 0);
    load(3); send(); wait_ov(e);
    for (int i = 0; i < VS; i++)
      chk($sformatf("lane_order[%0d]", i), longint'(result[i]),
          (i < 8) ? longint'(2147483632 + 2*i) : longint'(2*i - 15));

    // Back-pressure: hold DONE for 10 cycles while in_valid pulses
    @(posedge clk); #1;
    out_ready = 1'b0;
    load(4); send(); wait_ov(e);
    repeat (10) begin
      @(posedge clk); #1;
      in_valid = ($urandom_range(0, 1) == 1);
      v1[3] = 31'($urandom_range(0, 1000));
      chk("bp_out_valid", longint'(out_valid), 1);
      chk("bp_in_ready", longint'(in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_in_ready", longint'(in_ready), 1);
    chk("bp_release_out_valid", longint'(out_valid), 0);

    // Reset during beat 2 of COMPUTE
    load(4); send();
    @(posedge clk); @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", longint'(in_ready), 1);
    chk("midrst_out_valid", longint'(out_valid), 0);
    chk("midrst_busy", longint'(busy), 0);
    chk_all("midrst_result", 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    load(3); send(); wait_ov(e);
    chk("post_rst_result5", longint'(result[5]), 2147483642);

`ifdef M31_VEC_SUB_CANONICAL_EN
    @(posedge clk); #1;
    load(5); send(); wait_ov(e);
    chk_all("canon_p_minus_1", 2147483646);
    @(posedge clk); #1;
    load(6); send(); wait_ov(e);
    chk_all("canon_p_minus_0", 0);
`endif

    // Randomised traffic with random back-pressure
    @(posedge clk); #1;
    repeat (600) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      load(4);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    if (n_acc < 20) chk("random_accepts_low", n_acc, 20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
